// File: rtl/noise_voice_sched_pkg.sv
// Shared types and constants for the time-multiplexed noise voice scheduler.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package noise_voice_sched_pkg;

    localparam logic [15:0]        LFSR_SEED  = 16'hACE1;
    localparam logic signed [16:0] SAMPLE_MAX = 17'sd32767;
    localparam logic signed [16:0] SAMPLE_MIN = -17'sd32768;

    // Per-voice architectural state; counter never exceeds crush while enabled.
    typedef struct packed {
        logic        en;
        logic [16:0] crush;
        logic [16:0] counter;
        logic [15:0] lfsr;
    } voice_state_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } sched_state_t;

    // Right-shifting Fibonacci LFSR, taps on bits 0, 2, 3 and 5.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // Full-scale square sample from the LFSR output bit; silent when disabled.
    function automatic logic signed [16:0] voice_sample(input voice_state_t v);
        if (!v.en) begin
            return '0;
        end
        return v.lfsr[0] ? SAMPLE_MAX : SAMPLE_MIN;
    endfunction

endpackage

// File: rtl/noise_lfsr_step.sv
// Shared noise datapath: computes one voice's sample and its post-sample state.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to commit the next state.
module noise_lfsr_step
    import noise_voice_sched_pkg::*;
(
    input  voice_state_t       cur,
    output voice_state_t       nxt,
    output logic signed [16:0] sample
);

    // Crush counter gates LFSR advance; a disabled voice is frozen.
    always_comb begin
        nxt = cur;
        if (cur.en) begin
            if (cur.counter >= cur.crush) begin
                nxt.counter = '0;
                nxt.lfsr    = lfsr_next(cur.lfsr);
            end else begin
                nxt.counter = cur.counter + 17'd1;
            end
        end
    end

    assign sample = voice_sample(cur);

endmodule

// File: rtl/noise_voice_sched.sv
// Sweeps all noise voices through one shared LFSR step on every sample_tick.
// Latency: first sample valid 1 cycle after the tick, then one voice per cycle.
// Backpressure: outputs hold while out_ready is low; ticks arriving mid-sweep are dropped and flagged.
module noise_voice_sched
    import noise_voice_sched_pkg::*;
#(
    parameter int          NUM_VOICES = 4,
    parameter logic [15:0] SEED       = LFSR_SEED,
    localparam int         VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_tick,
    input  logic               cfg_we,
    input  logic [VW-1:0]      cfg_voice,
    input  logic               cfg_en,
    input  logic [16:0]        cfg_crush,
    input  logic               cfg_reseed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VW-1:0]      out_voice,
    output logic signed [16:0] out_sample,
    output logic               busy,
    output logic               overrun
);

    sched_state_t       state;
    sched_state_t       state_nxt;
    logic [VW-1:0]      idx;
    logic [VW-1:0]      idx_nxt;
    logic               load;
    logic               last;
    logic               hs;
    voice_state_t       voices [NUM_VOICES];
    voice_state_t       step_cur;
    voice_state_t       step_nxt;
    logic signed [16:0] step_sample;
    logic signed [16:0] entry_sample;

    assign last      = (idx == VW'(NUM_VOICES - 1));
    assign hs        = (state == ST_EMIT) && out_ready;
    assign out_valid = (state == ST_EMIT);
    assign busy      = (state == ST_EMIT);
    assign out_voice = idx;

    // While idle the datapath looks at voice 0 so its sample can be preloaded on the tick;
    // during a sweep it works on the displayed voice to produce the write-back.
    assign step_cur = (state == ST_EMIT) ? voices[idx] : voices[0];

    noise_lfsr_step u_step (
        .cur    (step_cur),
        .nxt    (step_nxt),
        .sample (step_sample)
    );

    // Sample of the voice about to be displayed: voice 0 from the datapath at sweep start,
    // otherwise a lookahead on the next voice, which has not been touched yet this sweep.
    assign entry_sample = (state == ST_IDLE) ? step_sample : voice_sample(voices[idx_nxt]);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, next-index and output-load decode.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample_tick) begin
                    state_nxt = ST_EMIT;
                    idx_nxt   = '0;
                    load      = 1'b1;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (last) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                        load    = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sweep index, held sample and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            out_sample <= '0;
            overrun    <= 1'b0;
        end else begin
            idx <= idx_nxt;
            if (load) begin
                out_sample <= entry_sample;
            end
            if (sample_tick && (state == ST_EMIT)) begin
                overrun <= 1'b1;
            end
        end
    end

    // Voice state: handshake write-back first, config write second so it takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                voices[v] <= '{en: 1'b0, crush: 17'd0, counter: 17'd0, lfsr: SEED};
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (hs && (idx == VW'(v))) begin
                    voices[v] <= step_nxt;
                end
                if (cfg_we && (cfg_voice == VW'(v))) begin
                    voices[v].en    <= cfg_en;
                    voices[v].crush <= cfg_crush;
                    if (cfg_reseed) begin
                        voices[v].lfsr    <= SEED;
                        voices[v].counter <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_noise_voice_sched.sv
// Directed bench for noise_voice_sched: table of whole-sweep vectors plus corner sequences.
// Latency: n/a.
// Backpressure: out_ready driven by the bench.
module tb_noise_voice_sched;

    localparam int          NV = 4;
    localparam logic [16:0] P  = 17'h07FFF;
    localparam logic [16:0] M  = 17'h18000;
    localparam logic [16:0] Z  = 17'h00000;

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_tick;
    logic               cfg_we;
    logic [1:0]         cfg_voice;
    logic               cfg_en;
    logic [16:0]        cfg_crush;
    logic               cfg_reseed;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_voice;
    logic signed [16:0] out_sample;
    logic               busy;
    logic               overrun;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    noise_voice_sched #(.NUM_VOICES(NV), .SEED(16'hACE1)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_en      (cfg_en),
        .cfg_crush   (cfg_crush),
        .cfg_reseed  (cfg_reseed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_voice   (out_voice),
        .out_sample  (out_sample),
        .busy        (busy),
        .overrun     (overrun)
    );

    typedef struct {
        logic             we;
        logic [1:0]       voice;
        logic             en;
        logic [16:0]      crush;
        logic             reseed;
        logic [3:0][16:0] s;
        logic [3:0][15:0] l;
    } vec_t;

    vec_t        tbl [11];
    logic [16:0] got_s [NV];
    logic [1:0]  got_v [NV];
    int          beats;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_row(input int i, input logic we, input logic [1:0] voice, input logic en,
                           input logic [16:0] crush, input logic reseed,
                           input logic [16:0] s0, input logic [16:0] s1,
                           input logic [16:0] s2, input logic [16:0] s3,
                           input logic [15:0] l0, input logic [15:0] l1,
                           input logic [15:0] l2, input logic [15:0] l3);
        tbl[i].we     = we;
        tbl[i].voice  = voice;
        tbl[i].en     = en;
        tbl[i].crush  = crush;
        tbl[i].reseed = reseed;
        tbl[i].s[0] = s0; tbl[i].s[1] = s1; tbl[i].s[2] = s2; tbl[i].s[3] = s3;
        tbl[i].l[0] = l0; tbl[i].l[1] = l1; tbl[i].l[2] = l2; tbl[i].l[3] = l3;
    endtask

    task automatic cfg_write(input logic [1:0] v, input logic en, input logic [16:0] cr, input logic rs);
        cfg_we = 1'b1; cfg_voice = v; cfg_en = en; cfg_crush = cr; cfg_reseed = rs;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_reseed = 1'b0;
    endtask

    // Tick with ready high and collect one beat per voice, bounded.
    task automatic sweep();
        beats = 0;
        out_ready = 1'b1;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        for (int c = 0; c < 40 && beats < NV; c++) begin
            if (out_valid) begin
                got_s[beats] = out_sample;
                got_v[beats] = out_voice;
                beats++;
            end
            @(posedge clk); #1;
        end
        check("sweep_beats", 17'(beats), 17'(NV));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          nvalid;
        int          nh;
        int          stalls;
        int          stable_bad;
        logic [16:0] held;
        logic [1:0]  order [NV];
        logic        found;

        rst = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_voice = '0; cfg_en = 1'b0;
        cfg_crush = '0; cfg_reseed = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 17'(out_valid), 17'd0);
        check("rst_voice", 17'(out_voice), 17'd0);
        check("rst_sample", out_sample, Z);
        check("rst_busy", 17'(busy), 17'd0);
        check("rst_overrun", 17'(overrun), 17'd0);
        check("rst_lfsr0", 17'(dut.voices[0].lfsr), 17'h0ACE1);
        rst = 1'b0;
        @(posedge clk); #1;

        //          we  vc en  crush rs   s0 s1 s2 s3   l0        l1        l2        l3
        set_row(0,  1, 0, 1, 17'd0, 0,   P, Z, Z, Z,   16'h5670, 16'hACE1, 16'hACE1, 16'hACE1);
        set_row(1,  0, 0, 0, 17'd0, 0,   M, Z, Z, Z,   16'hAB38, 16'hACE1, 16'hACE1, 16'hACE1);
        set_row(2,  1, 1, 1, 17'd2, 0,   M, P, Z, Z,   16'h559C, 16'hACE1, 16'hACE1, 16'hACE1);
        set_row(3,  1, 0, 0, 17'd0, 0,   Z, P, Z, Z,   16'h559C, 16'hACE1, 16'hACE1, 16'hACE1);
        set_row(4,  0, 0, 0, 17'd0, 0,   Z, P, Z, Z,   16'h559C, 16'h5670, 16'hACE1, 16'hACE1);
        set_row(5,  0, 0, 0, 17'd0, 0,   Z, M, Z, Z,   16'h559C, 16'h5670, 16'hACE1, 16'hACE1);
        set_row(6,  0, 0, 0, 17'd0, 0,   Z, M, Z, Z,   16'h559C, 16'h5670, 16'hACE1, 16'hACE1);
        set_row(7,  0, 0, 0, 17'd0, 0,   Z, M, Z, Z,   16'h559C, 16'hAB38, 16'hACE1, 16'hACE1);
        set_row(8,  1, 1, 1, 17'd0, 0,   Z, M, Z, Z,   16'h559C, 16'h559C, 16'hACE1, 16'hACE1);
        set_row(9,  1, 0, 1, 17'd0, 1,   P, M, Z, Z,   16'h5670, 16'h2ACE, 16'hACE1, 16'hACE1);
        set_row(10, 1, 3, 1, 17'd0, 0,   M, M, Z, P,   16'hAB38, 16'h1567, 16'hACE1, 16'h5670);

        for (int r = 0; r < 11; r++) begin
            if (tbl[r].we) begin
                cfg_write(tbl[r].voice, tbl[r].en, tbl[r].crush, tbl[r].reseed);
            end
            sweep();
            for (int v = 0; v < NV; v++) begin
                check($sformatf("row%0d_voice%0d", r, v), 17'(got_v[v]), 17'(v));
                check($sformatf("row%0d_sample%0d", r, v), got_s[v], tbl[r].s[v]);
                check($sformatf("row%0d_lfsr%0d", r, v), 17'(dut.voices[v].lfsr), 17'(tbl[r].l[v]));
            end
            check($sformatf("row%0d_idle", r), 17'(busy), 17'd0);
        end

        // Stall at voice 2 for 5 cycles; a config write to voice 2 must not disturb the held sample.
        nvalid = 0; nh = 0; stalls = 0; stable_bad = 0; held = '0;
        out_ready = 1'b1;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!out_valid) break;
            nvalid++;
            if (out_voice == 2'd2 && stalls < 5) begin
                if (stalls == 0) begin
                    held = out_sample;
                end else if (out_sample !== held || out_voice !== 2'd2) begin
                    stable_bad++;
                end
                if (stalls == 1) begin
                    cfg_we = 1'b1; cfg_voice = 2'd2; cfg_en = 1'b1; cfg_crush = 17'd0;
                end
                out_ready = 1'b0;
                stalls++;
            end else begin
                if (out_voice == 2'd2 && out_sample !== held) begin
                    stable_bad++;
                end
                out_ready = 1'b1;
                if (nh < NV) begin
                    order[nh] = out_voice;
                end
                nh++;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
        end
        out_ready = 1'b1;
        check("stall_valid_cycles", 17'(nvalid), 17'd9);
        check("stall_handshakes", 17'(nh), 17'(NV));
        check("stall_held_value", held, Z);
        check("stall_unstable_cycles", 17'(stable_bad), 17'd0);
        for (int v = 0; v < NV; v++) begin
            check($sformatf("stall_order%0d", v), 17'(order[v]), 17'(v));
        end

        // Second tick two cycles into a sweep, then a tick on the final handshake.
        check("pre_overrun", 17'(overrun), 17'd0);
        nvalid = 0;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) nvalid++;
            sample_tick = (c == 1) || (out_valid && out_voice == 2'd3);
            @(posedge clk); #1;
        end
        sample_tick = 1'b0;
        check("overrun_beats", 17'(nvalid), 17'(NV));
        check("overrun_flag", 17'(overrun), 17'd1);
        check("overrun_idle", 17'(busy), 17'd0);

        // Reseed of voice 0 in its own handshake cycle beats the write-back.
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        check("reseed_hs_voice", 17'(out_voice), 17'd0);
        cfg_we = 1'b1; cfg_voice = 2'd0; cfg_en = 1'b1; cfg_crush = 17'd0; cfg_reseed = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_reseed = 1'b0;
        check("reseed_lfsr", 17'(dut.voices[0].lfsr), 17'h0ACE1);
        check("reseed_counter", dut.voices[0].counter, 17'd0);
        for (int c = 0; c < 20 && out_valid; c++) begin
            @(posedge clk); #1;
        end
        check("reseed_drained", 17'(out_valid), 17'd0);

        // Asynchronous reset in the middle of a sweep.
        found = 1'b0;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && out_voice == 2'd2) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("midreset_reached_v2", 17'(found), 17'd1);
        rst = 1'b1;
        #1;
        check("midreset_valid", 17'(out_valid), 17'd0);
        check("midreset_busy", 17'(busy), 17'd0);
        check("midreset_overrun", 17'(overrun), 17'd0);
        check("midreset_sample", out_sample, Z);
        for (int v = 0; v < NV; v++) begin
            check($sformatf("midreset_lfsr%0d", v), 17'(dut.voices[v].lfsr), 17'h0ACE1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        sweep();
        for (int v = 0; v < NV; v++) begin
            check($sformatf("postreset_voice%0d", v), 17'(got_v[v]), 17'(v));
            check($sformatf("postreset_sample%0d", v), got_s[v], Z);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
